// File: rtl/uart_pkt_pkg.sv
// Shared encodings for the UART packet transmitter: FSM states, parity modes,
// packet field selects and the parity helper.
package uart_pkt_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HDR    = 4'd1,
    S_FETCH  = 4'd2,
    S_LATCH  = 4'd3,
    S_START  = 4'd4,
    S_DATA   = 4'd5,
    S_PARITY = 4'd6,
    S_STOP   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [1:0] {
    FLD_SOF  = 2'd0,
    FLD_LEN  = 2'd1,
    FLD_PAY  = 2'd2,
    FLD_CSUM = 2'd3
  } field_t;

  // Callers zero-extend narrower characters; extra zeros do not change the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_char_tx.sv
// Single-character UART serializer: start bit, LSB-first data, optional parity,
// one or two stop bits. The baud counter restarts at every accepted character.
module uart_char_tx
  import uart_pkt_pkg::*;
#(
  parameter int BAUD_DIV    = 434,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  char_valid,
  input  logic [DATA_WIDTH-1:0] char_data,
  output logic                  char_ready,
  output logic                  char_done,
  output logic                  serial_out,
  output state_t                phase
);

  localparam int                BAUD_W    = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit                HAS_PAR   = (PARITY_MODE != PARITY_NONE);

  logic [BAUD_W-1:0]     baud_cnt;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  bit_end;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign char_ready = (phase == S_IDLE);
  // Early completion strobe lets the sequencer line up the next character.
  assign char_done  = (phase == S_STOP) && bit_end && (bit_cnt == STOP_LAST);

  // NOTE: async reset forces the line idle at once, even mid-character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= S_IDLE;
      serial_out <= 1'b1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
    end else if (phase == S_IDLE) begin
      // NOTE: non-blocking everywhere so each register samples pre-edge values.
      if (char_valid) begin
        shreg      <= char_data;
        par_bit    <= calc_parity(9'(char_data), PARITY_MODE);
        serial_out <= 1'b0;
        baud_cnt   <= '0;
        phase      <= S_START;
      end
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      case (phase)
        S_START: begin
          serial_out <= shreg[0];
          shreg      <= shreg >> 1;
          bit_cnt    <= '0;
          phase      <= S_DATA;
        end
        S_DATA: begin
          if (bit_cnt != DATA_LAST) begin
            serial_out <= shreg[0];
            shreg      <= shreg >> 1;
            bit_cnt    <= bit_cnt + 1'b1;
          end else if (HAS_PAR) begin
            serial_out <= par_bit;
            phase      <= S_PARITY;
          end else begin
            serial_out <= 1'b1;
            bit_cnt    <= '0;
            phase      <= S_STOP;
          end
        end
        S_PARITY: begin
          serial_out <= 1'b1;
          bit_cnt    <= '0;
          phase      <= S_STOP;
        end
        S_STOP: begin
          if (bit_cnt == STOP_LAST) phase <= S_IDLE;
          else                      bit_cnt <= bit_cnt + 1'b1;
        end
        default: begin
          serial_out <= 1'b1;
          phase      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_pkt_tx.sv
// UART packetizer: drains the TX FIFO into SOF, LEN, payload, XOR-checksum
// packets and hands each character to uart_char_tx.
module uart_pkt_tx
  import uart_pkt_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1,
  parameter int PKT_LEN     = 16,
  parameter int SOF_CHAR    = 'hA5,
  parameter int LVL_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic [LVL_W-1:0]      fifo_level,
  output logic                  fifo_read_en,
  input  logic                  flush,
  input  logic                  tx_ready,
  output logic                  serial_out,
  output logic                  tx_busy,
  output logic                  pkt_done,
  output logic [3:0]            debug_state
);

  localparam int                    BAUD_DIV    = CLK_FREQ / BAUD_RATE;
  localparam logic [LVL_W-1:0]      PKT_LEN_LVL = LVL_W'(PKT_LEN);
  localparam logic [DATA_WIDTH-1:0] PKT_LEN_D   = DATA_WIDTH'(PKT_LEN);
  localparam logic [DATA_WIDTH-1:0] SOF_D       = DATA_WIDTH'(SOF_CHAR);

  state_t                state;
  state_t                tx_phase;
  state_t                cur_state;
  field_t                field;
  logic [DATA_WIDTH-1:0] len;
  logic [DATA_WIDTH-1:0] csum;
  logic [DATA_WIDTH-1:0] pay_cnt;
  logic [DATA_WIDTH-1:0] char_data;
  logic [DATA_WIDTH-1:0] len_next;
  logic                  char_valid;
  logic                  char_ready;
  logic                  char_done;
  logic                  start_ok;

  assign start_ok   = tx_ready &&
                      ((fifo_level >= PKT_LEN_LVL) || (flush && (fifo_level != '0)));
  assign len_next   = (fifo_level >= PKT_LEN_LVL) ? PKT_LEN_D : DATA_WIDTH'(fifo_level);
  assign char_valid = (state == S_HDR) || (state == S_LATCH);
  // While a character is on the wire the serializer owns the reported state.
  assign cur_state  = (state == S_START) ? tx_phase : state;

  always_comb begin
    // NOTE: default first so no path leaves char_data unassigned (no latch).
    char_data = SOF_D;
    case (field)
      FLD_LEN:  char_data = len;
      FLD_PAY:  char_data = fifo_data;
      FLD_CSUM: char_data = csum;
      default:  char_data = SOF_D;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      field        <= FLD_SOF;
      len          <= '0;
      csum         <= '0;
      pay_cnt      <= '0;
      tx_busy      <= 1'b0;
      pkt_done     <= 1'b0;
      fifo_read_en <= 1'b0;
      debug_state  <= S_IDLE;
    end else begin
      pkt_done     <= 1'b0;
      fifo_read_en <= 1'b0;
      debug_state  <= cur_state;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            len     <= len_next;
            csum    <= '0;
            pay_cnt <= '0;
            field   <= FLD_SOF;
            tx_busy <= 1'b1;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (char_ready) begin
            if (field == FLD_LEN) csum <= csum ^ len;
            state <= S_START;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          if (char_ready) begin
            csum    <= csum ^ fifo_data;
            pay_cnt <= pay_cnt + 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          if (char_done) begin
            case (field)
              FLD_SOF: begin
                field <= FLD_LEN;
                state <= S_HDR;
              end
              FLD_LEN: begin
                field        <= FLD_PAY;
                fifo_read_en <= 1'b1;
                state        <= S_FETCH;
              end
              FLD_PAY: begin
                if (pay_cnt == len) begin
                  field <= FLD_CSUM;
                  state <= S_HDR;
                end else begin
                  fifo_read_en <= 1'b1;
                  state        <= S_FETCH;
                end
              end
              default: begin
                tx_busy  <= 1'b0;
                pkt_done <= 1'b1;
                state    <= S_DONE;
              end
            endcase
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          tx_busy <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  uart_char_tx #(
    .BAUD_DIV    (BAUD_DIV),
    .DATA_WIDTH  (DATA_WIDTH),
    .PARITY_MODE (PARITY_MODE),
    .STOP_BITS   (STOP_BITS)
  ) u_char_tx (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .char_done  (char_done),
    .serial_out (serial_out),
    .phase      (tx_phase)
  );

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed bench for uart_pkt_tx: three framings (8N1, 8E2, 7O1) at 10 clk/bit,
// line decoded by sampling mid-bit, FIFO modelled with read-latency of one clock.
module tb_uart_pkt_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] rdy, fl, so, busy, done, rd;
  logic [8:0] fd  [3];
  logic [7:0] lvl [3];
  logic [3:0] ds  [3];

  logic [8:0] mem [3][16];
  int wr_ptr   [3] = '{default: 0};
  int rd_ptr   [3] = '{default: 0};
  int rd_cnt   [3] = '{default: 0};
  int done_cnt [3] = '{default: 0};
  int low_cnt  [3] = '{default: 0};
  int busy_cnt [3] = '{default: 0};
  int viol     [3] = '{default: 0};
  logic [2:0] rd_q = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  assign lvl[0] = 8'(wr_ptr[0] - rd_ptr[0]);
  assign lvl[1] = 8'(wr_ptr[1] - rd_ptr[1]);
  assign lvl[2] = 8'(wr_ptr[2] - rd_ptr[2]);

  uart_pkt_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_WIDTH(8), .PARITY_MODE(0),
                .STOP_BITS(1), .PKT_LEN(4), .SOF_CHAR('hA5), .LVL_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_data(fd[0][7:0]), .fifo_level(lvl[0]), .fifo_read_en(rd[0]),
    .flush(fl[0]), .tx_ready(rdy[0]), .serial_out(so[0]), .tx_busy(busy[0]),
    .pkt_done(done[0]), .debug_state(ds[0]));

  uart_pkt_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_WIDTH(8), .PARITY_MODE(1),
                .STOP_BITS(2), .PKT_LEN(4), .SOF_CHAR('hA5), .LVL_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_data(fd[1][7:0]), .fifo_level(lvl[1]), .fifo_read_en(rd[1]),
    .flush(fl[1]), .tx_ready(rdy[1]), .serial_out(so[1]), .tx_busy(busy[1]),
    .pkt_done(done[1]), .debug_state(ds[1]));

  uart_pkt_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_WIDTH(7), .PARITY_MODE(2),
                .STOP_BITS(1), .PKT_LEN(2), .SOF_CHAR('hA5), .LVL_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_data(fd[2][6:0]), .fifo_level(lvl[2]), .fifo_read_en(rd[2]),
    .flush(fl[2]), .tx_ready(rdy[2]), .serial_out(so[2]), .tx_busy(busy[2]),
    .pkt_done(done[2]), .debug_state(ds[2]));

  // FIFO model and protocol monitors.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd[k]) begin
        fd[k]     <= mem[k][rd_ptr[k]];
        rd_ptr[k] <= rd_ptr[k] + 1;
        rd_cnt[k] <= rd_cnt[k] + 1;
        if (rd_q[k] || !busy[k]) viol[k] <= viol[k] + 1;
      end
      if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
    end
    rd_q <= rd;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (so[k] == 1'b0) low_cnt[k]  <= low_cnt[k] + 1;
      if (busy[k])       busy_cnt[k] <= busy_cnt[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [8:0] v);
    mem[k][wr_ptr[k]] = v;
    wr_ptr[k]++;
  endtask

  function automatic int exp_par(input int d, input int pm);
    logic p;
    p = ^d;
    return (pm == 2) ? int'(!p) : int'(p);
  endfunction

  // Waits for a start bit, then samples each bit in its middle.
  task automatic rx_char(input int k, input int dw, input int pm, input int sb,
                         output int data, output int par, output int stop_ok, output bit ok);
    int waited = 0;
    data = 0; par = 0; stop_ok = 1; ok = 1'b1;
    while (so[k] !== 1'b0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (so[k] !== 1'b0) begin
      ok = 1'b0;
      check($sformatf("dut%0d start bit timeout", k), 32'(so[k]), 0);
      return;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < dw; i++) begin
      repeat (10) @(negedge clk);
      data |= int'(so[k]) << i;
    end
    if (pm != 0) begin
      repeat (10) @(negedge clk);
      par = int'(so[k]);
    end
    for (int i = 0; i < sb; i++) begin
      repeat (10) @(negedge clk);
      if (so[k] !== 1'b1) stop_ok = 0;
    end
  endtask

  task automatic expect_pkt(input string tag, input int k, input int dw, input int pm, input int sb);
    int d, p, s, cyc, snap;
    bit ok;
    snap = done_cnt[k];
    for (int i = 0; i < exp_q.size(); i++) begin
      rx_char(k, dw, pm, sb, d, p, s, ok);
      if (!ok) return;
      check($sformatf("%s char%0d", tag, i), d, exp_q[i]);
      if (pm != 0) check($sformatf("%s par%0d", tag, i), p, exp_par(exp_q[i], pm));
      check($sformatf("%s stop%0d", tag, i), s, 1);
    end
    cyc = 0;
    while (done_cnt[k] == snap && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s pkt_done count", tag), done_cnt[k] - snap, 1);
    check($sformatf("%s busy after done", tag), 32'(busy[k]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lc, bc, rc, d, p, s, w;
    bit ok;
    rst = 1'b1; rdy = '0; fl = '0;
    repeat (3) @(negedge clk);
    check("reset serial_out", 32'(so), 32'b111);
    check("reset tx_busy", 32'(busy), 0);
    check("reset pkt_done", 32'(done), 0);
    check("reset fifo_read_en", 32'(rd), 0);
    check("reset debug_state", 32'(ds[0]), 0);
    rst = 1'b0;

    // Full FIFO but no permission: line must stay idle.
    push(0, 9'h11); push(0, 9'h22); push(0, 9'h33); push(0, 9'h44);
    lc = low_cnt[0]; bc = busy_cnt[0];
    repeat (30) @(negedge clk);
    check("no tx_ready line low samples", low_cnt[0] - lc, 0);
    check("no tx_ready busy samples", busy_cnt[0] - bc, 0);

    rc = rd_cnt[0];
    rdy[0] = 1'b1;
    @(negedge clk);
    check("busy one clock after start", 32'(busy[0]), 1);
    @(negedge clk);
    check("SOF start bit within 2 clocks", 32'(so[0]), 0);
    check("debug_state lags in HDR", 32'(ds[0]), 1);
    // csum = 04^11^22^33^44
    exp_q = {8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
    expect_pkt("8n1", 0, 8, 0, 1);
    check("8n1 fifo reads", rd_cnt[0] - rc, 4);
    repeat (3) @(negedge clk);
    check("8n1 debug_state idle", 32'(ds[0]), 0);
    rdy[0] = 1'b0;

    // Even parity, two stop bits, single-char flush packet.
    push(1, 9'h07); fl[1] = 1'b1; rdy[1] = 1'b1;
    exp_q = {8'hA5, 8'h01, 8'h07, 8'h06};
    expect_pkt("8e2", 1, 8, 1, 2);
    fl[1] = 1'b0; rdy[1] = 1'b0;

    // 7-bit odd parity, SOF truncated to 7 bits.
    push(2, 9'h7F); push(2, 9'h01); rdy[2] = 1'b1;
    exp_q = {8'h25, 8'h02, 8'h7F, 8'h01, 8'h7C};
    expect_pkt("7o1", 2, 7, 2, 1);
    rdy[2] = 1'b0;

    // Short FIFO needs flush.
    push(0, 9'h5A); push(0, 9'hC3); push(0, 9'h0F);
    rdy[0] = 1'b1;
    lc = low_cnt[0]; bc = busy_cnt[0];
    repeat (30) @(negedge clk);
    check("short no flush line low", low_cnt[0] - lc, 0);
    check("short no flush busy", busy_cnt[0] - bc, 0);
    rc = rd_cnt[0];
    fl[0] = 1'b1;
    exp_q = {8'hA5, 8'h03, 8'h5A, 8'hC3, 8'h0F, 8'h95};
    expect_pkt("flush", 0, 8, 0, 1);
    check("flush fifo reads", rd_cnt[0] - rc, 3);
    fl[0] = 1'b0;

    // Reset during payload bit 3 of the first payload character (0x01).
    push(0, 9'h01); push(0, 9'h02); push(0, 9'h03); push(0, 9'h04);
    rx_char(0, 8, 0, 1, d, p, s, ok);
    check("rst pkt SOF", d, 8'hA5);
    rx_char(0, 8, 0, 1, d, p, s, ok);
    check("rst pkt LEN", d, 8'h04);
    w = 0;
    while (so[0] !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (44) @(negedge clk);
    check("payload bit3 low before reset", 32'(so[0]), 0);
    rst = 1'b1;
    #1;
    check("reset mid-packet line high", 32'(so[0]), 1);
    check("reset mid-packet busy low", 32'(busy[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    lc = low_cnt[0]; bc = busy_cnt[0];
    repeat (30) @(negedge clk);
    check("after reset line idle", low_cnt[0] - lc, 0);
    check("after reset not busy", busy_cnt[0] - bc, 0);
    check("after reset fifo level", 32'(lvl[0]), 3);
    fl[0] = 1'b1;
    exp_q = {8'hA5, 8'h03, 8'h02, 8'h03, 8'h04, 8'h06};
    expect_pkt("post-reset", 0, 8, 0, 1);
    fl[0] = 1'b0; rdy[0] = 1'b0;

    check("read_en protocol violations", viol[0] + viol[1] + viol[2], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
